id_stage: RTL



---
 rtl/isa_pkg.sv | 56 +++++
 rtl/reg_file.sv | 54 +++++
 rtl/id_stage.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode stage: widths, opcodes, ALU op classes,
// instruction field positions and the decoded control bundle.
package isa_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;
  localparam int IMM_W      = 6;

  // Instruction field bit positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RS_MSB  = 11;
  localparam int RS_LSB  = 9;
  localparam int RT_MSB  = 8;
  localparam int RT_LSB  = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 3;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_RTYPE = 4'b0000,
    OP_ADDI  = 4'b0001,
    OP_LW    = 4'b0100,
    OP_SW    = 4'b0101,
    OP_BEQ   = 4'b0110,
    OP_NOP   = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_FUNC = 2'b10
  } alu_op_e;

  // Decoded control bundle, in the order ID/EX consumes it
  typedef struct packed {
    logic    regDst;
    logic    aluSrc;
    logic    memToReg;
    logic    regWrite;
    logic    memRead;
    logic    memWrite;
    logic    branch;
    alu_op_e aluOp;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '{default: '0, aluOp: ALU_ADD};

  // Replicates the top immediate bit across the upper datapath bits
  function automatic logic [DATA_W-1:0] signExtend(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/reg_file.sv
// 8x16 register file with two combinational read ports, one write port,
// write-to-read bypass and r0 hardwired to zero.
module reg_file
  import isa_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_ADDR_W,
  parameter int NR = NUM_REGS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr1_i,
  input  logic [AW-1:0] raddr2_i,
  output logic [DW-1:0] rdata1_o,
  output logic [DW-1:0] rdata2_o
);

  logic [DW-1:0] regs_q [NR];
  logic          writeEn;

  // r0 is never stored, so a write aimed at it is simply dropped
  assign writeEn = we_i && (waddr_i != '0);

  // Storage array: cleared asynchronously, written on the rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        regs_q[i] <= '0;
      end
    end else if (writeEn) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports: r0 reads zero, a same-cycle writeback is forwarded, else the array
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    rdata2_o = regs_q[raddr2_i];
    if (raddr1_i == '0) begin
      rdata1_o = '0;
    end else if (writeEn && (waddr_i == raddr1_i)) begin
      rdata1_o = wdata_i;
    end
    if (raddr2_i == '0) begin
      rdata2_o = '0;
    end else if (writeEn && (waddr_i == raddr2_i)) begin
      rdata2_o = wdata_i;
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: register file read, control decode, immediate
// sign extension, load-use hazard detection with a one-cycle bubble, and a
// saturating count of stall cycles.
module id_stage
  import isa_pkg::*;
#(
  parameter int DATA_W     = isa_pkg::DATA_W,
  parameter int REG_ADDR_W = isa_pkg::REG_ADDR_W,
  parameter int NUM_REGS   = isa_pkg::NUM_REGS,
  parameter int IMM_W      = isa_pkg::IMM_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hit,
  input  logic [DATA_W-1:0]     instr_in,
  input  logic [DATA_W-1:0]     adder_pc_in,
  input  logic                  flush_in,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_write_reg,
  input  logic [DATA_W-1:0]     wb_write_data,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  output logic [DATA_W-1:0]     adder_pc_out,
  output logic [DATA_W-1:0]     read_data_1_out,
  output logic [DATA_W-1:0]     read_data_2_out,
  output logic [DATA_W-1:0]     sign_extended_immediate_out,
  output logic [REG_ADDR_W-1:0] rt_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  RegDst_out,
  output logic                  ALUSrc_out,
  output logic                  MemToReg_out,
  output logic                  RegWrite_out,
  output logic                  MemRead_out,
  output logic                  MemWrite_out,
  output logic                  Branch_out,
  output logic [1:0]            ALUOp_out,
  output logic                  stall,
  output logic                  illegal_op,
  output logic [15:0]           stall_count
);

  logic [3:0]            opcode;
  logic [REG_ADDR_W-1:0] rsField;
  logic [REG_ADDR_W-1:0] rtField;
  logic [REG_ADDR_W-1:0] rdField;
  logic [IMM_W-1:0]      immField;
  ctrl_t                 decCtrl;
  ctrl_t                 outCtrl;
  logic                  decIllegal;
  logic                  usesRt;
  logic                  bubble;
  logic [15:0]           stallCount_q;
  logic [15:0]           stallCount_d;

  assign opcode   = instr_in[OP_MSB:OP_LSB];
  assign rsField  = instr_in[RS_MSB:RS_LSB];
  assign rtField  = instr_in[RT_MSB:RT_LSB];
  assign rdField  = instr_in[RD_MSB:RD_LSB];
  assign immField = instr_in[IMM_MSB:IMM_LSB];

  reg_file #(
    .DW(DATA_W),
    .AW(REG_ADDR_W),
    .NR(NUM_REGS)
  ) u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wb_reg_write),
    .waddr_i (wb_write_reg),
    .wdata_i (wb_write_data),
    .raddr1_i(rsField),
    .raddr2_i(rtField),
    .rdata1_o(read_data_1_out),
    .rdata2_o(read_data_2_out)
  );

  // Opcode decode into the control bundle; unknown opcodes decode as a bubble and flag illegal
  always_comb begin
    decCtrl    = CTRL_NONE;
    decIllegal = 1'b0;
    usesRt     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        decCtrl.regDst   = 1'b1;
        decCtrl.regWrite = 1'b1;
        decCtrl.aluOp    = ALU_FUNC;
        usesRt           = 1'b1;
      end
      OP_ADDI: begin
        decCtrl.aluSrc   = 1'b1;
        decCtrl.regWrite = 1'b1;
      end
      OP_LW: begin
        decCtrl.aluSrc   = 1'b1;
        decCtrl.memToReg = 1'b1;
        decCtrl.regWrite = 1'b1;
        decCtrl.memRead  = 1'b1;
      end
      OP_SW: begin
        decCtrl.aluSrc   = 1'b1;
        decCtrl.memWrite = 1'b1;
        usesRt           = 1'b1;
      end
      OP_BEQ: begin
        decCtrl.branch   = 1'b1;
        decCtrl.aluOp    = ALU_SUB;
        usesRt           = 1'b1;
      end
      OP_NOP: begin
        decCtrl = CTRL_NONE;
      end
      default: begin
        decIllegal = 1'b1;
      end
    endcase
  end

  // Load-use detection: the load in ID/EX targets a register this instruction reads.
  // Stall stays asserted under flush so PC logic can still see it and prioritise the redirect.
  always_comb begin
    stall = ex_mem_read && (ex_rt != '0) &&
            ((ex_rt == rsField) || (usesRt && (ex_rt == rtField)));
  end

  // Either a stall or a flush turns this slot into a bubble
  always_comb begin
    bubble     = stall || flush_in;
    outCtrl    = bubble ? CTRL_NONE : decCtrl;
    illegal_op = decIllegal && !flush_in;
  end

  assign RegDst_out   = outCtrl.regDst;
  assign ALUSrc_out   = outCtrl.aluSrc;
  assign MemToReg_out = outCtrl.memToReg;
  assign RegWrite_out = outCtrl.regWrite;
  assign MemRead_out  = outCtrl.memRead;
  assign MemWrite_out = outCtrl.memWrite;
  assign Branch_out   = outCtrl.branch;
  assign ALUOp_out    = outCtrl.aluOp;

  assign adder_pc_out                = adder_pc_in;
  assign rt_out                      = rtField;
  assign rd_out                      = rdField;
  assign sign_extended_immediate_out = signExtend(immField);

  // Next stall count: advance only on a real stall while the cache is not freezing us, and stick at all-ones
  always_comb begin
    stallCount_d = stallCount_q;
    if (stall && hit && (stallCount_q != 16'hFFFF)) begin
      stallCount_d = stallCount_q + 16'd1;
    end
  end

  // Stall counter register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCount_q <= '0;
    end else begin
      stallCount_q <= stallCount_d;
    end
  end

  assign stall_count = stallCount_q;

endmodule
